input_port_sampler: RTL and testbench
=====================================

// Module: input_port_sampler
// PURPOSE
//  Memory-mapped input port at the I/O window (addr[7:0] >= 8'ha0); read-side counterpart of output_control.
//  Synchronises and debounces switch inputs input1/input2 and latches stable values.
//  Records per-channel change flags and an event count; CPU reads them via addr, clears flags via data_write.
//  Drives input_out in computer; the top's memory/IO select on data_out is unchanged.
// PARAMETERS
//  WIDTH            5    switch bits per channel
//  DEBOUNCE_CYCLES  1000 consecutive clock cycles a new level must hold before acceptance (>=2)
//  CNT_W            10   debounce counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//  clock       in   1      CPU clock; all state updates on rising edge
//  reset       in   1      synchronous, active-high
//  addr        in   32     CPU data address; only addr[7:0] decoded
//  wdata       in   32     CPU store data (mem_in)
//  data_write  in   1      store strobe to I/O window (output_write && !memory)
//  input1      in   WIDTH  raw asynchronous switches, channel 1
//  input2      in   WIDTH  raw asynchronous switches, channel 2
//  rdata       out  32     combinational read data for addr
//  changed     out  1      OR of both change flags (registered state)
// BEHAVIOUR
//  Reset: sync1/sync2, stable, counters, chg1/chg2 and evt_cnt all <= 0 at the first rising edge with reset=1.
//   Hence rdata reads 0 at every address and changed=0. reset wins over every other event.
//  Sync: per channel, two-flop synchroniser sync1<=inN, sync2<=sync1 (whole WIDTH-bit vector).
//  Debounce, per channel, at each edge:
//   - sync2 == stable -> cnt <= 0
//   - sync2 != stable, cnt == DEBOUNCE_CYCLES-1 -> stable <= sync2, cnt <= 0, chgN <= 1, evt_cnt <= evt_cnt+1
//   - otherwise cnt <= cnt+1
//   - glitch (sync2 returns to stable before the limit) -> cnt reset, no update, no flag.
//   - sync2 moves to a third value mid-count -> count continues; the value present at the limit edge is latched.
//  Latency: a raw change held steady before edge k becomes visible in stable after edge k+1+DEBOUNCE_CYCLES.
//  Address map (addr[7:0]); rdata is combinational, unused bits 0:
//   8'ha0  {27'b0, stable1}
//   8'ha4  {27'b0, stable2}
//   8'ha8  {30'b0, chg2, chg1}
//   8'hac  {24'b0, evt_cnt}
//   others  32'b0
//  Flag clear: data_write && addr[7:0]==8'ha8 -> chg1 <= chg1 & ~wdata[0], chg2 <= chg2 & ~wdata[1] (write-1-to-clear).
//   Set and clear of the same flag on the same edge: set wins (flag stays 1).
//  evt_cnt: 8-bit; both channels updating on one edge -> +2. Wraps 8'hff -> 8'h00 (no saturation).
//   Write to 8'hac: evt_cnt <= 0; a same-edge increment is lost (clear wins).
//  Writes to 8'ha0/8'ha4/other addresses are ignored. Reads have no side effects.
//  changed = chg1 | chg2.
// STRUCTURE
//  Shared package io_map_pkg:
//   IO_BASE=8'ha0, IN1_ADDR=8'ha0, IN2_ADDR=8'ha4, STAT_ADDR=8'ha8, EVT_ADDR=8'hac.
//   Also shared by the top-level decode and output_control.
//  Sub-module debounce_channel (WIDTH, DEBOUNCE_CYCLES, CNT_W):
//   ports clock, reset, raw, stable, update_pulse; instantiated twice.
//  Top of this block: address decode, flags, evt_cnt, read mux.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  Reset with input1=5'h1f held -> rdata 0 at a0/a8/ac; stable1=5'h1f after edge 6 from reset release, chg1=1, evt_cnt=1.
//  input1 5'h00->5'h0a before edge 0 -> a0 reads 0 through edge 4, 32'h0a after edge 5; a8 reads 1; changed=1.
//  input2 pulses 5'h03 for 3 cycles then returns to 0 -> a4 stays 0, chg2=0, evt_cnt unchanged.
//  Store wdata=32'h1 to a8 on the same edge chg2 sets -> a8 reads 32'h2; next store 32'h3 -> reads 0, changed=0.
//  Same-edge set and clear: store 32'h1 to a8 on the edge chg1 sets -> chg1 stays 1.
//  Both channels change simultaneously -> evt_cnt +2; 128 such pairs from 0 -> evt_cnt wraps to 8'h00.
//  reset asserted mid-debounce (cnt=2) -> all state 0 next edge; stable unchanged until a full 4-cycle hold after release.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared I/O window map: register addresses and the address-to-register decode.
package io_map_pkg;

    localparam logic [7:0] IO_BASE   = 8'ha0;
    localparam logic [7:0] IN1_ADDR  = 8'ha0;
    localparam logic [7:0] IN2_ADDR  = 8'ha4;
    localparam logic [7:0] STAT_ADDR = 8'ha8;
    localparam logic [7:0] EVT_ADDR  = 8'hac;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_IN1,
        SEL_IN2,
        SEL_STAT,
        SEL_EVT
    } io_sel_e;

    // Maps the low address byte onto the register it selects.
    function automatic io_sel_e decode_sel(input logic [7:0] a);
        io_sel_e sel;
        case (a)
            IN1_ADDR:  sel = SEL_IN1;
            IN2_ADDR:  sel = SEL_IN2;
            STAT_ADDR: sel = SEL_STAT;
            EVT_ADDR:  sel = SEL_EVT;
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchroniser followed by a hold-time debouncer.
// update_pulse is high during the cycle whose rising edge loads a new stable value.
module debounce_channel #(
    parameter int unsigned WIDTH           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable,
    output logic             update_pulse
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differ;
    logic             at_limit;

    // Next-state for the debouncer: count while the synchronised level differs
    // from the accepted one; whatever value is present at the limit is taken.
    always_comb begin
        differ       = (sync2_q != stable_q);
        at_limit     = (cnt_q == LIMIT);
        update_pulse = differ && at_limit;
        stable_d     = stable_q;
        cnt_d        = cnt_q;
        if (!differ) begin
            cnt_d = '0;
        end else if (at_limit) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchroniser, accepted value and hold counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/input_port_sampler.sv
// Memory-mapped input port: two debounced switch channels, sticky change
// flags (write-1-to-clear) and an 8-bit wrapping event counter.
module input_port_sampler
    import io_map_pkg::*;
#(
    parameter int unsigned WIDTH           = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned CNT_W           = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic             data_write,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic [31:0]      rdata,
    output logic             changed
);

    logic [WIDTH-1:0] stable1;
    logic [WIDTH-1:0] stable2;
    logic             upd1;
    logic             upd2;
    logic             chg1_q;
    logic             chg1_d;
    logic             chg2_q;
    logic             chg2_d;
    logic [7:0]       evt_cnt_q;
    logic [7:0]       evt_cnt_d;
    io_sel_e          sel;
    logic             stat_wr;
    logic             evt_wr;
    logic             unused_bits;

    assign unused_bits = ^{addr[31:8], wdata[31:2]};

    debounce_channel #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch1 (
        .clock        (clock),
        .reset        (reset),
        .raw          (input1),
        .stable       (stable1),
        .update_pulse (upd1)
    );

    debounce_channel #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch2 (
        .clock        (clock),
        .reset        (reset),
        .raw          (input2),
        .stable       (stable2),
        .update_pulse (upd2)
    );

    // Store decode and next-state for flags and event counter.
    // A flag set beats a same-edge clear; a counter clear beats a same-edge increment.
    always_comb begin
        sel       = decode_sel(addr[7:0]);
        stat_wr   = data_write && (sel == SEL_STAT);
        evt_wr    = data_write && (sel == SEL_EVT);
        chg1_d    = upd1 | (chg1_q & ~(stat_wr & wdata[0]));
        chg2_d    = upd2 | (chg2_q & ~(stat_wr & wdata[1]));
        evt_cnt_d = evt_cnt_q + 8'(upd1) + 8'(upd2);
        if (evt_wr) begin
            evt_cnt_d = '0;
        end
    end

    // Flag and event counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            chg1_q    <= 1'b0;
            chg2_q    <= 1'b0;
            evt_cnt_q <= '0;
        end else begin
            chg1_q    <= chg1_d;
            chg2_q    <= chg2_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    // Combinational read mux; unmapped addresses and unused bits read 0.
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_IN1:  rdata = 32'(stable1);
            SEL_IN2:  rdata = 32'(stable2);
            SEL_STAT: rdata = {30'b0, chg2_q, chg1_q};
            SEL_EVT:  rdata = {24'b0, evt_cnt_q};
            default:  rdata = '0;
        endcase
    end

    assign changed = chg1_q | chg2_q;

endmodule

// File: tb/tb_input_port_sampler.sv
// Directed bench for input_port_sampler with a 4-cycle debounce hold.
module tb_input_port_sampler;
    import io_map_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        data_write;
    logic [4:0]  input1;
    logic [4:0]  input2;
    logic [31:0] rdata;
    logic        changed;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [4:0]  v1;
    logic [4:0]  v2;

    input_port_sampler #(
        .WIDTH           (5),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .addr       (addr),
        .wdata      (wdata),
        .data_write (data_write),
        .input1     (input1),
        .input2     (input2),
        .rdata      (rdata),
        .changed    (changed)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        addr = {24'h0, a};
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic store(input logic [7:0] a, input logic [31:0] d);
        addr       = {24'h0, a};
        wdata      = d;
        data_write = 1'b1;
        tick(1);
        data_write = 1'b0;
        wdata      = '0;
    endtask

    initial begin
        reset      = 1'b1;
        input1     = 5'h1f;
        input2     = 5'h00;
        addr       = '0;
        wdata      = '0;
        data_write = 1'b0;

        // Reset with input1 held high
        tick(2);
        rd("rst_a0", IN1_ADDR, 32'h0);
        rd("rst_a4", IN2_ADDR, 32'h0);
        rd("rst_a8", STAT_ADDR, 32'h0);
        rd("rst_ac", EVT_ADDR, 32'h0);
        check("rst_changed", {31'b0, changed}, 32'h0);
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            rd($sformatf("rel_hold_e%0d", e), IN1_ADDR, 32'h0);
        end
        tick(1);
        rd("rel_a0", IN1_ADDR, 32'h1f);
        rd("rel_a8", STAT_ADDR, 32'h1);
        rd("rel_ac", EVT_ADDR, 32'h1);
        check("rel_changed", {31'b0, changed}, 32'h1);
        store(STAT_ADDR, 32'h1);
        rd("clr1_a8", STAT_ADDR, 32'h0);
        store(EVT_ADDR, 32'h0);
        rd("clr_ac", EVT_ADDR, 32'h0);

        // Clean 0 -> 0a change on channel 1
        reset  = 1'b1;
        input1 = 5'h00;
        tick(2);
        reset = 1'b0;
        tick(3);
        rd("idle_a0", IN1_ADDR, 32'h0);
        input1 = 5'h0a;
        for (int e = 0; e <= 4; e++) begin
            tick(1);
            rd($sformatf("lat_e%0d", e), IN1_ADDR, 32'h0);
        end
        tick(1);
        rd("lat_a0", IN1_ADDR, 32'h0a);
        rd("lat_a8", STAT_ADDR, 32'h1);
        check("lat_changed", {31'b0, changed}, 32'h1);
        rd("lat_ac", EVT_ADDR, 32'h1);
        store(IN1_ADDR, 32'hffff_ffff);
        rd("ign_a0", IN1_ADDR, 32'h0a);
        rd("ign_a8", STAT_ADDR, 32'h1);
        store(STAT_ADDR, 32'h3);
        store(EVT_ADDR, 32'h0);

        // Three-cycle glitch on channel 2
        input2 = 5'h03;
        tick(3);
        input2 = 5'h00;
        tick(8);
        rd("gl_a4", IN2_ADDR, 32'h0);
        rd("gl_a8", STAT_ADDR, 32'h0);
        rd("gl_ac", EVT_ADDR, 32'h0);

        // Clear chg1 (already 0) on the edge chg2 sets
        input2 = 5'h03;
        tick(5);
        store(STAT_ADDR, 32'h1);
        rd("c2set_a8", STAT_ADDR, 32'h2);
        rd("c2set_a4", IN2_ADDR, 32'h3);
        store(STAT_ADDR, 32'h3);
        rd("c2clr_a8", STAT_ADDR, 32'h0);
        check("c2clr_changed", {31'b0, changed}, 32'h0);
        rd("c2_ac", EVT_ADDR, 32'h1);

        // Same-edge set and clear of chg1
        input1 = 5'h15;
        tick(5);
        store(STAT_ADDR, 32'h1);
        rd("setwin_a8", STAT_ADDR, 32'h1);
        rd("setwin_a0", IN1_ADDR, 32'h15);
        rd("setwin_ac", EVT_ADDR, 32'h2);
        store(STAT_ADDR, 32'h3);
        store(EVT_ADDR, 32'h0);

        // Counter clear on the same edge as an increment
        input1 = 5'h0a;
        tick(5);
        store(EVT_ADDR, 32'h0);
        rd("evtclr_ac", EVT_ADDR, 32'h0);
        rd("evtclr_a0", IN1_ADDR, 32'h0a);
        rd("evtclr_a8", STAT_ADDR, 32'h1);
        store(STAT_ADDR, 32'h3);

        // Simultaneous changes: +2 per pair, 128 pairs wrap to 0
        v1 = 5'h0a;
        v2 = 5'h03;
        for (int i = 1; i <= 128; i++) begin
            v1     = ~v1;
            v2     = ~v2;
            input1 = v1;
            input2 = v2;
            tick(6);
            if (i == 1)   rd("pair1_ac", EVT_ADDR, 32'h2);
            if (i == 127) rd("pair127_ac", EVT_ADDR, 32'hfe);
        end
        rd("wrap_ac", EVT_ADDR, 32'h0);
        rd("wrap_a0", IN1_ADDR, {27'b0, v1});
        rd("wrap_a4", IN2_ADDR, {27'b0, v2});
        store(STAT_ADDR, 32'h3);
        store(EVT_ADDR, 32'h0);

        // Reset mid-debounce with the counter at 2
        v1     = 5'h11;
        input1 = v1;
        tick(4);
        reset = 1'b1;
        tick(1);
        rd("mid_a0", IN1_ADDR, 32'h0);
        rd("mid_a4", IN2_ADDR, 32'h0);
        rd("mid_a8", STAT_ADDR, 32'h0);
        rd("mid_ac", EVT_ADDR, 32'h0);
        check("mid_changed", {31'b0, changed}, 32'h0);
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick(1);
            rd($sformatf("mid_hold_e%0d", e), IN1_ADDR, 32'h0);
        end
        tick(1);
        rd("mid_rel_a0", IN1_ADDR, {27'b0, v1});
        rd("mid_rel_a4", IN2_ADDR, {27'b0, v2});
        rd("mid_rel_ac", EVT_ADDR, 32'h2);
        rd("other_addr", 8'hb0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
